// File: rtl/axis_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen_pkg
// Shared types and helpers for the AXI-Stream test-pattern generator.
//   state_t     : command FSM states (IDLE, SEND, GAP)
//   mode_t      : data pattern selection
//   LFSR_POLY   : Galois tap mask for x^32 + x^22 + x^2 + x + 1
//   last_keep() : byte-enable mask for the final beat of a packet
// -----------------------------------------------------------------------------
package axis_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_INC_BYTE = 2'd0,
    MODE_BEAT_CNT = 2'd1,
    MODE_LFSR     = 2'd2,
    MODE_PKT_TAG  = 2'd3
  } mode_t;

  // Right-shifting Galois form: tap bit (n-1) for each term x^n, n = 32, 22, 2, 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Widest supported beat (512-bit tdata).
  localparam int unsigned MAX_BYTES = 64;

  // Final-beat keep: the low 'rem' bytes, or a full beat when rem is zero.
  function automatic logic [MAX_BYTES-1:0] last_keep(input int unsigned rem,
                                                     input int unsigned bytes);
    logic [MAX_BYTES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if ((rem == 0) ? (i < bytes) : (i < rem)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_pattern_generator_lfsr32_step.sv
// -----------------------------------------------------------------------------
// lfsr32_step
// Combinational single step of a 32-bit Galois LFSR (x^32+x^22+x^2+x+1).
//   cur : current register value
//   nxt : value after one shift
// -----------------------------------------------------------------------------
module lfsr32_step
  import axis_pattern_gen_pkg::*;
(
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  always_comb begin
    nxt = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h0);
  end

endmodule

// File: rtl/axis_pattern_generator.sv
// -----------------------------------------------------------------------------
// axis_pattern_generator
// AXI-Stream master emitting bursts of test packets per start command.
//   aclk, areset            : clock, synchronous active-high reset
//   i_start                 : start pulse, only honoured in IDLE
//   i_mode                  : 0 INC_BYTE, 1 BEAT_CNT, 2 LFSR, 3 PKT_TAG
//   i_byte_len              : bytes per packet
//   i_pkt_count             : packets per command
//   i_gap_cycles            : idle cycles between packets
//   o_busy, o_done          : command in progress / one-cycle completion pulse
//   m_axis_*                : registered AXI-Stream master outputs
// -----------------------------------------------------------------------------
module axis_pattern_generator
  import axis_pattern_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 32,
  parameter logic [7:0]  START_BYTE = 8'h80,
  parameter logic [31:0] LFSR_SEED  = 32'hFFFF_FFFF
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    i_start,
  input  logic [1:0]              i_mode,
  input  logic [LEN_WIDTH-1:0]    i_byte_len,
  input  logic [15:0]             i_pkt_count,
  input  logic [7:0]              i_gap_cycles,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH:0] BYTES_W = (LEN_WIDTH + 1)'(BYTES);

  // Latched command and per-beat position; the *_q set always describes the
  // beat currently sitting on the output registers.
  state_t               state_q, state_n;
  mode_t                mode_q, mode_n;
  logic [LEN_WIDTH-1:0] len_q, len_n;
  logic [LEN_WIDTH-1:0] byte_off_q, byte_off_n;  // first byte of beat in packet
  logic [LEN_WIDTH-1:0] beat_q, beat_n;          // beat number, from 1
  logic [15:0]          pkt_left_q, pkt_left_n;  // packets left incl. current
  logic [15:0]          pkt_idx_q, pkt_idx_n;    // packet number, from 0
  logic [7:0]           gap_q, gap_n;
  logic [7:0]           gap_cnt_q, gap_cnt_n;
  logic [31:0]          lfsr_q, lfsr_n, lfsr_adv;

  logic load_beat;   // register the formatted beat built from the *_n values
  logic clear_beat;  // drop the stream outputs to zero
  logic done_n;
  logic accept;

  // Beat formatter outputs
  logic [LEN_WIDTH-1:0]  rem_bytes;
  int unsigned           rem_mod;
  logic                  fmt_last;
  logic [BYTES-1:0]      fmt_keep;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic [DATA_WIDTH-1:0] beat_word;
  logic [DATA_WIDTH-1:0] lfsr_word;
  logic [7:0]            byte_v;

  assign accept = m_axis_tvalid & m_axis_tready;

  lfsr32_step u_lfsr (
    .cur (lfsr_q),
    .nxt (lfsr_adv)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n    = state_q;
    mode_n     = mode_q;
    len_n      = len_q;
    byte_off_n = byte_off_q;
    beat_n     = beat_q;
    pkt_left_n = pkt_left_q;
    pkt_idx_n  = pkt_idx_q;
    gap_n      = gap_q;
    gap_cnt_n  = gap_cnt_q;
    lfsr_n     = lfsr_q;
    load_beat  = 1'b0;
    clear_beat = 1'b0;
    done_n     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if ((i_byte_len != '0) && (i_pkt_count != '0)) begin
            mode_n     = mode_t'(i_mode);
            len_n      = i_byte_len;
            gap_n      = i_gap_cycles;
            pkt_left_n = i_pkt_count;
            pkt_idx_n  = '0;
            byte_off_n = '0;
            beat_n     = LEN_WIDTH'(1);
            lfsr_n     = LFSR_SEED;
            load_beat  = 1'b1;
            state_n    = SEND;
          end else begin
            done_n = 1'b1;  // empty command completes without any beats
          end
        end
      end

      SEND: begin
        if (accept) begin
          lfsr_n = lfsr_adv;  // runs on across packet boundaries
          if (!m_axis_tlast) begin
            byte_off_n = byte_off_q + LEN_WIDTH'(BYTES);
            beat_n     = beat_q + LEN_WIDTH'(1);
            load_beat  = 1'b1;
          end else if (pkt_left_q == 16'd1) begin
            clear_beat = 1'b1;
            done_n     = 1'b1;
            state_n    = IDLE;
          end else begin
            pkt_left_n = pkt_left_q - 16'd1;
            pkt_idx_n  = pkt_idx_q + 16'd1;
            byte_off_n = '0;
            beat_n     = LEN_WIDTH'(1);
            if (gap_q == 8'd0) begin
              load_beat = 1'b1;
            end else begin
              gap_cnt_n  = gap_q;
              clear_beat = 1'b1;
              state_n    = GAP;
            end
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == 8'd1) begin
          load_beat = 1'b1;
          state_n   = SEND;
        end else begin
          gap_cnt_n = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        clear_beat = 1'b1;
        state_n    = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat formatter: builds the beat described by the *_n position values
  // ---------------------------------------------------------------------------
  always_comb begin
    rem_bytes = len_n - byte_off_n;
    fmt_last  = ({1'b0, rem_bytes} <= BYTES_W);
    // On the final beat the bytes still owed equal len mod BYTES, except that
    // a full beat means the remainder is zero; this avoids a divider on len.
    rem_mod = 0;
    if ({1'b0, rem_bytes} < BYTES_W) rem_mod = 32'(rem_bytes);
    fmt_keep  = fmt_last ? BYTES'(last_keep(rem_mod, BYTES)) : '1;
    beat_word = DATA_WIDTH'(beat_n);
    for (int i = 0; i < DATA_WIDTH; i++) lfsr_word[i] = lfsr_n[i % 32];

    fmt_data = '0;
    byte_v   = '0;
    for (int k = 0; k < int'(BYTES); k++) begin
      unique case (mode_n)
        MODE_INC_BYTE: byte_v = START_BYTE + 8'(byte_off_n) + 8'(k);
        MODE_BEAT_CNT: byte_v = beat_word[8*k +: 8];
        MODE_LFSR:     byte_v = lfsr_word[8*k +: 8];
        MODE_PKT_TAG:  byte_v = pkt_idx_n[7:0];
        default:       byte_v = 8'h00;
      endcase
      if (fmt_keep[k]) fmt_data[8*k +: 8] = byte_v;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every flop samples the
  // values that existed before the edge regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      mode_q        <= MODE_INC_BYTE;
      len_q         <= '0;
      byte_off_q    <= '0;
      beat_q        <= '0;
      pkt_left_q    <= '0;
      pkt_idx_q     <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      lfsr_q        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      len_q      <= len_n;
      byte_off_q <= byte_off_n;
      beat_q     <= beat_n;
      pkt_left_q <= pkt_left_n;
      pkt_idx_q  <= pkt_idx_n;
      gap_q      <= gap_n;
      gap_cnt_q  <= gap_cnt_n;
      lfsr_q     <= lfsr_n;
      o_busy     <= (state_n != IDLE);
      o_done     <= done_n;
      // Outputs hold otherwise, which keeps a stalled beat stable.
      if (load_beat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= fmt_data;
        m_axis_tkeep  <= fmt_keep;
        m_axis_tlast  <= fmt_last;
      end else if (clear_beat) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_axis_pattern_generator
// Directed self-checking bench for axis_pattern_generator (32-bit data).
// -----------------------------------------------------------------------------
module tb_axis_pattern_generator;

  logic        aclk = 1'b0;
  logic        areset;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [31:0] i_byte_len;
  logic [15:0] i_pkt_count;
  logic [7:0]  i_gap_cycles;
  logic        o_busy;
  logic        o_done;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int checks = 0;
  int errors = 0;

  // Captured beats of the most recent command
  logic [31:0] cap_data[$];
  logic [3:0]  cap_keep[$];
  logic        cap_last[$];
  int          cap_cyc[$];
  int          done_cyc;
  logic        done_busy;

  always #5 aclk = ~aclk;

  axis_pattern_generator dut (
    .aclk          (aclk),
    .areset        (areset),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_byte_len    (i_byte_len),
    .i_pkt_count   (i_pkt_count),
    .i_gap_cycles  (i_gap_cycles),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_start(input logic [1:0] mode, input logic [31:0] len,
                            input logic [15:0] cnt, input logic [7:0] gap);
    i_mode       = mode;
    i_byte_len   = len;
    i_pkt_count  = cnt;
    i_gap_cycles = gap;
    i_start      = 1'b1;
    step();
    i_start      = 1'b0;
  endtask

  // Collect accepted beats until o_done is seen. ready_mode 0: tready always
  // high; 1: tready pattern 1,0,0 repeating. poke: pulse i_start (with a
  // different configuration) while the command is running.
  task automatic collect(input int ready_mode, input int budget, input bit poke);
    logic        prev_stall;
    logic [31:0] p_data;
    logic [3:0]  p_keep;
    logic        p_last;
    cap_data.delete();
    cap_keep.delete();
    cap_last.delete();
    cap_cyc.delete();
    done_cyc   = -1;
    done_busy  = 1'b1;
    prev_stall = 1'b0;
    p_data     = '0;
    p_keep     = '0;
    p_last     = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (o_done) begin
        done_cyc  = cyc;
        done_busy = o_busy;
        break;
      end
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, p_data);
        check("stall_keep", m_axis_tkeep, p_keep);
        check("stall_last", m_axis_tlast, p_last);
      end
      m_axis_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (poke && cyc == 1) begin
        i_start      = 1'b1;
        i_mode       = 2'd0;
        i_byte_len   = 32'd100;
        i_pkt_count  = 16'd9;
        i_gap_cycles = 8'd5;
      end else begin
        i_start = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_data.push_back(m_axis_tdata);
        cap_keep.push_back(m_axis_tkeep);
        cap_last.push_back(m_axis_tlast);
        cap_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      p_data     = m_axis_tdata;
      p_keep     = m_axis_tkeep;
      p_last     = m_axis_tlast;
      step();
    end
    i_start = 1'b0;
    check("done_within_budget", (done_cyc >= 0), 1);
  endtask

  task automatic exp_beat(input string tag, input int idx, input logic [31:0] d,
                          input logic [3:0] k, input logic l);
    if (idx < cap_data.size()) begin
      check({tag, "_data"}, cap_data[idx], d);
      check({tag, "_keep"}, cap_keep[idx], k);
      check({tag, "_last"}, cap_last[idx], l);
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  // Cycles between two captured beats with tvalid low (tready held high).
  function automatic int gap_between(input int a, input int b);
    if (b < cap_cyc.size()) return cap_cyc[b] - cap_cyc[a] - 1;
    return -1;
  endfunction

  task automatic check_inc10(input string tag);
    check({tag, "_beats"}, cap_data.size(), 3);
    exp_beat({tag, "_b1"}, 0, 32'h8382_8180, 4'hF, 1'b0);
    exp_beat({tag, "_b2"}, 1, 32'h8786_8584, 4'hF, 1'b0);
    exp_beat({tag, "_b3"}, 2, 32'h0000_8988, 4'h3, 1'b1);
  endtask

  initial begin
    areset        = 1'b1;
    i_start       = 1'b0;
    i_mode        = 2'd0;
    i_byte_len    = '0;
    i_pkt_count   = '0;
    i_gap_cycles  = '0;
    m_axis_tready = 1'b0;
    repeat (3) step();
    check("rst_valid", m_axis_tvalid, 0);
    check("rst_data", m_axis_tdata, 0);
    check("rst_keep", m_axis_tkeep, 0);
    check("rst_last", m_axis_tlast, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    areset = 1'b0;
    step();

    // INC_BYTE, 10 bytes, one packet, tready high
    send_start(2'd0, 32'd10, 16'd1, 8'd0);
    check("t1_latency_valid", m_axis_tvalid, 1);
    check("t1_busy", o_busy, 1);
    collect(0, 50, 1'b0);
    check_inc10("t1");
    if (cap_cyc.size() == 3) check("t1_done_cycle", done_cyc, cap_cyc[2] + 1);
    else check("t1_done_cycle", 0, 1);
    check("t1_busy_at_done", done_busy, 0);
    step();
    check("t1_done_one_cycle", o_done, 0);

    // Same command under back-pressure
    send_start(2'd0, 32'd10, 16'd1, 8'd0);
    collect(1, 100, 1'b0);
    check_inc10("t2");
    step();

    // BEAT_CNT, 8 bytes, 3 packets, gap 2
    send_start(2'd1, 32'd8, 16'd3, 8'd2);
    collect(0, 100, 1'b0);
    check("t3_beats", cap_data.size(), 6);
    for (int p = 0; p < 3; p++) begin
      exp_beat($sformatf("t3_p%0d_b1", p), 2*p, 32'd1, 4'hF, 1'b0);
      exp_beat($sformatf("t3_p%0d_b2", p), 2*p + 1, 32'd2, 4'hF, 1'b1);
    end
    check("t3_gap01", gap_between(1, 2), 2);
    check("t3_gap12", gap_between(3, 4), 2);
    check("t3_busy_at_done", done_busy, 0);
    step();

    // LFSR, 12 bytes, 2 packets back-to-back
    send_start(2'd2, 32'd12, 16'd2, 8'd0);
    collect(0, 100, 1'b0);
    check("t4_beats", cap_data.size(), 6);
    exp_beat("t4_b1", 0, 32'hFFFF_FFFF, 4'hF, 1'b0);
    exp_beat("t4_b2", 1, 32'hFFDF_FFFC, 4'hF, 1'b0);
    exp_beat("t4_b3", 2, 32'h7FEF_FFFE, 4'hF, 1'b1);
    exp_beat("t4_b4", 3, 32'h3FF7_FFFF, 4'hF, 1'b0);
    exp_beat("t4_b5", 4, 32'h9FDB_FFFC, 4'hF, 1'b0);
    exp_beat("t4_b6", 5, 32'h4FED_FFFE, 4'hF, 1'b1);
    check("t4_no_bubble", gap_between(2, 3), 0);
    step();

    // Zero length: no beats, single done pulse
    send_start(2'd0, 32'd0, 16'd5, 8'd0);
    check("t5_valid", m_axis_tvalid, 0);
    check("t5_busy", o_busy, 0);
    collect(0, 20, 1'b0);
    check("t5_beats", cap_data.size(), 0);
    check("t5_done_cycle", done_cyc, 0);
    step();
    check("t5_done_one_cycle", o_done, 0);
    check("t5_valid_after", m_axis_tvalid, 0);

    // PKT_TAG, 4 bytes, 3 packets, with a start poke while busy
    send_start(2'd3, 32'd4, 16'd3, 8'd1);
    collect(0, 100, 1'b1);
    check("t6_beats", cap_data.size(), 3);
    exp_beat("t6_p0", 0, 32'h0000_0000, 4'hF, 1'b1);
    exp_beat("t6_p1", 1, 32'h0101_0101, 4'hF, 1'b1);
    exp_beat("t6_p2", 2, 32'h0202_0202, 4'hF, 1'b1);
    step();
    check("t6_no_restart", o_busy, 0);
    check("t6_no_restart_valid", m_axis_tvalid, 0);

    // Reset in the middle of beat 2, then a fresh command
    send_start(2'd0, 32'd10, 16'd1, 8'd0);
    check("t7_b1_data", m_axis_tdata, 32'h8382_8180);
    m_axis_tready = 1'b1;
    step();
    check("t7_b2_data", m_axis_tdata, 32'h8786_8584);
    m_axis_tready = 1'b0;
    areset        = 1'b1;
    step();
    areset = 1'b0;
    check("t7_rst_valid", m_axis_tvalid, 0);
    check("t7_rst_last", m_axis_tlast, 0);
    check("t7_rst_busy", o_busy, 0);
    step();
    send_start(2'd0, 32'd10, 16'd1, 8'd0);
    collect(0, 50, 1'b0);
    check_inc10("t7_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
